nand_1b_cell: RTL and testbench

Single-bit NAND primitive for the gate-level datapath library. It provides the combinational NAND output `o` and the other basic gates, each built only from NAND instances. It also provides a registered copy of `o` and a saturating toggle counter used for activity and coverage checks. It is the leaf cell that higher-level adders and muxes instantiate.

---
 rtl/gate_lib_pkg.sv | 8 +
 rtl/nand_1b.sv | 10 +
 rtl/nand_1b_cell.sv | 63 ++++++
 tb/tb_nand_1b_cell.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gate_lib_pkg.sv
// Shared constants for the gate-level datapath library cells.
package gate_lib_pkg;

  localparam int   DEF_CNT_W    = 8;
  // NAND of the idle inputs (0,0); reset value of every registered NAND output.
  localparam logic NAND_RST_VAL = 1'b1;

endpackage

// File: rtl/nand_1b.sv
// Two-input NAND primitive; every other gate in the cell is composed of these.
module nand_1b (
  input  logic a,
  input  logic b,
  output logic o
);

  assign o = ~(a & b);

endmodule

// File: rtl/nand_1b_cell.sv
// Single-bit NAND cell: NAND-only derived gates, registered NAND output and
// a saturating toggle counter for activity/coverage checks.
module nand_1b_cell
  import gate_lib_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  output logic             o,
  output logic             not_x,
  output logic             and_o,
  output logic             or_o,
  output logic             nor_o,
  output logic             xor_o,
  output logic             xnor_o,
  output logic             o_q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] tog_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic not_y;
  logic xor_l;
  logic xor_r;
  logic o_q_reg;
  logic [CNT_W-1:0] tog_cnt_reg;

  nand_1b u_nand   (.a(x),     .b(y),     .o(o));
  nand_1b u_not_x  (.a(x),     .b(x),     .o(not_x));
  nand_1b u_not_y  (.a(y),     .b(y),     .o(not_y));
  nand_1b u_and    (.a(o),     .b(o),     .o(and_o));
  nand_1b u_or     (.a(not_x), .b(not_y), .o(or_o));
  nand_1b u_nor    (.a(or_o),  .b(or_o),  .o(nor_o));

  // Classic 4-NAND XOR; the first NAND of the structure is the shared o.
  nand_1b u_xor_l  (.a(x),     .b(o),     .o(xor_l));
  nand_1b u_xor_r  (.a(y),     .b(o),     .o(xor_r));
  nand_1b u_xor    (.a(xor_l), .b(xor_r), .o(xor_o));
  nand_1b u_xnor   (.a(xor_o), .b(xor_o), .o(xnor_o));

  // Clear beats a same-edge toggle; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q_reg     <= NAND_RST_VAL;
      tog_cnt_reg <= '0;
    end else begin
      o_q_reg <= o;
      if (cnt_clr) begin
        tog_cnt_reg <= '0;
      end else if ((o != o_q_reg) && (tog_cnt_reg != CNT_MAX)) begin
        tog_cnt_reg <= tog_cnt_reg + 1'b1;
      end
    end
  end

  assign o_q     = o_q_reg;
  assign tog_cnt = tog_cnt_reg;

endmodule

// File: tb/tb_nand_1b_cell.sv
// Directed bench for nand_1b_cell: expectations queued at drive time, popped
// and asserted when the outputs are sampled.
module tb_nand_1b_cell;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x, y, cnt_clr;
  logic       o, not_x, and_o, or_o, nor_o, xor_o, xnor_o, o_q;
  logic [7:0] tog_cnt;

  logic       x2, y2, cnt_clr2;
  logic       o2, not_x2, and_o2, or_o2, nor_o2, xor_o2, xnor_o2, o_q2;
  logic [1:0] tog_cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  nand_1b_cell #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .o(o), .not_x(not_x),
    .and_o(and_o), .or_o(or_o), .nor_o(nor_o), .xor_o(xor_o),
    .xnor_o(xnor_o), .o_q(o_q), .cnt_clr(cnt_clr), .tog_cnt(tog_cnt)
  );

  nand_1b_cell #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .o(o2), .not_x(not_x2),
    .and_o(and_o2), .or_o(or_o2), .nor_o(nor_o2), .xor_o(xor_o2),
    .xnor_o(xnor_o2), .o_q(o_q2), .cnt_clr(cnt_clr2), .tog_cnt(tog_cnt2)
  );

  task automatic push(input string tag, input logic [7:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    item_t it;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0h expected none", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
    end
    $display("[%0t] %s obs=%0h exp=%0h", $time, it.tag, obs, it.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_state(input string tag, input logic oq, input logic [7:0] cnt);
    push({tag, "_o_q"}, {7'd0, oq});
    push({tag, "_tog_cnt"}, cnt);
  endtask

  task automatic chk_state();
    pop_check({7'd0, o_q});
    pop_check(tog_cnt);
  endtask

  initial begin
    logic [3:0] tx, ty, t_o, t_and, t_xor, t_nor, t_not, t_or, t_xnor;
    logic [4:0] sat_cnt [5];
    tx = 4'b1010;  ty = 4'b1100;           // bit i = step i: (0,0),(1,0),(0,1),(1,1)
    t_o = 4'b0111; t_and = 4'b1000; t_xor = 4'b0110; t_nor = 4'b0001;
    t_not = 4'b0101; t_or = 4'b1110; t_xnor = 4'b1001;
    sat_cnt = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3};

    rst_n = 1'b0; x = 1'b0; y = 1'b0; cnt_clr = 1'b0;
    x2 = 1'b0; y2 = 1'b0; cnt_clr2 = 1'b0;

    // Truth table while held in reset: combinational path ignores rst_n.
    #2;
    for (int i = 0; i < 4; i++) begin
      x = tx[i]; y = ty[i];
      push($sformatf("tt%0d_o", i),      {7'd0, t_o[i]});
      push($sformatf("tt%0d_and", i),    {7'd0, t_and[i]});
      push($sformatf("tt%0d_xor", i),    {7'd0, t_xor[i]});
      push($sformatf("tt%0d_nor", i),    {7'd0, t_nor[i]});
      push($sformatf("tt%0d_not_x", i),  {7'd0, t_not[i]});
      push($sformatf("tt%0d_or", i),     {7'd0, t_or[i]});
      push($sformatf("tt%0d_xnor", i),   {7'd0, t_xnor[i]});
      #1;
      pop_check({7'd0, o});     pop_check({7'd0, and_o});
      pop_check({7'd0, xor_o}); pop_check({7'd0, nor_o});
      pop_check({7'd0, not_x}); pop_check({7'd0, or_o});
      pop_check({7'd0, xnor_o});
      #9;
    end
    exp_state("in_reset", 1'b1, 8'd0);
    chk_state();

    // Idle after reset release.
    tick();
    x = 1'b0; y = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_state($sformatf("idle%0d", i), 1'b1, 8'd0);
      tick();
      chk_state();
    end

    // Latency: o immediate, o_q and tog_cnt one edge later.
    x = 1'b1; y = 1'b1;
    push("lat_o_now", 8'd0);
    push("lat_o_q_before_edge", 8'd1);
    #1;
    pop_check({7'd0, o});
    pop_check({7'd0, o_q});
    exp_state("lat_edge", 1'b0, 8'd1);
    tick();
    chk_state();

    // Build the count up to 5 with o_q = 0.
    for (int i = 0; i < 4; i++) begin
      x = (i % 2 == 1); y = (i % 2 == 1);
      exp_state($sformatf("tog%0d", i), (i % 2 == 0), 8'(i + 2));
      tick();
      chk_state();
    end
    exp_state("hold", 1'b0, 8'd5);
    tick();
    chk_state();

    // Asynchronous reset mid-cycle, then holds through an edge.
    rst_n = 1'b0;
    exp_state("async_rst", 1'b1, 8'd0);
    #1;
    chk_state();
    exp_state("rst_hold", 1'b1, 8'd0);
    tick();
    chk_state();

    // Release with o = 0: first edge counts a toggle.
    rst_n = 1'b1;
    exp_state("first_edge", 1'b0, 8'd1);
    tick();
    chk_state();

    // Clear wins over a same-edge toggle.
    x = 1'b0; y = 1'b0; cnt_clr = 1'b1;
    exp_state("clr_prio", 1'b1, 8'd0);
    tick();
    chk_state();
    cnt_clr = 1'b0;

    // Glitch between edges is not counted.
    x = 1'b1; y = 1'b1;
    #1;
    x = 1'b0; y = 1'b0;
    exp_state("glitch", 1'b1, 8'd0);
    tick();
    chk_state();

    x = 1'b1; y = 1'b1;
    exp_state("after_clr", 1'b0, 8'd1);
    tick();
    chk_state();

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      x2 = (i % 2 == 0); y2 = (i % 2 == 0);
      push($sformatf("sat%0d_o_q", i), {7'd0, (i % 2 == 1)});
      push($sformatf("sat%0d_tog_cnt", i), {3'd0, sat_cnt[i]});
      tick();
      pop_check({7'd0, o_q2});
      pop_check({6'd0, tog_cnt2});
    end
    x2 = 1'b1; y2 = 1'b1; cnt_clr2 = 1'b1;
    push("sat_clr_tog_cnt", 8'd0);
    tick();
    pop_check({6'd0, tog_cnt2});
    cnt_clr2 = 1'b0;

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
